// File: rtl/apb3_to_ahb_bridge.sv
// -----------------------------------------------------------------------------
// apb3_to_ahb_bridge
// APB3 completer that forwards each APB transfer as a single AHB-Lite
// NONSEQ/SINGLE word transfer and returns the AHB response to the APB side.
//
// Optional build macro: APB3TOAHB_TIMEOUT_EN
//   When defined, an AHB stall of TIMEOUT_CYCLES cycles in ADDR or DATA ends
//   the transfer with PSLVERR=1. When undefined, stalls wait indefinitely.
//
// Ports
//   HCLK, HRESET                 clock (rising edge), async active-high reset
//   PSEL, PENABLE, PWRITE        APB3 control in
//   PADDR[31:0], PWDATA[31:0]    APB3 address / write data in
//   PRDATA[31:0], PREADY,        APB3 read data / completion / error out
//   PSLVERR
//   HADDR[31:0], HTRANS[1:0],    AHB-Lite address phase out
//   HWRITE, HSIZE[2:0], HBURST[2:0]
//   HWDATA[31:0]                 AHB-Lite write data out
//   HRDATA[31:0], HREADY, HRESP  AHB-Lite response in
// -----------------------------------------------------------------------------
module apb3_to_ahb_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  // state | meaning
  // IDLE  | waiting for an APB setup phase
  // ADDR  | AHB address phase (NONSEQ) until HREADY
  // DATA  | AHB data phase until HREADY, response captured on exit
  // RESP  | one-cycle PREADY pulse back to APB
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_write;
  logic        r_err;
  logic        w_capture;
  logic        w_ahb_done;

`ifdef APB3TOAHB_TIMEOUT_EN
  localparam logic [15:0] LP_STALL_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_stall_cnt;
  logic        w_stall_expired;
  logic        w_timeout;

  assign w_stall_expired = (r_stall_cnt == LP_STALL_LAST);

  // Counts consecutive stall cycles within one state; any state change restarts it.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_stall_cnt <= '0;
    end else if (w_next != r_state) begin
      r_stall_cnt <= '0;
    end else if ((r_state == S_ADDR || r_state == S_DATA) && !HREADY) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  logic w_unused;
  assign w_unused = ^PADDR[1:0];
`else
  logic w_unused;
  assign w_unused = ^{PADDR[1:0], TIMEOUT_CYCLES};
`endif

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_capture  = 1'b0;
    w_ahb_done = 1'b0;
`ifdef APB3TOAHB_TIMEOUT_EN
    w_timeout  = 1'b0;
`endif
    HTRANS     = 2'b00;
    HSIZE      = 3'b000;
    PREADY     = 1'b0;
    PSLVERR    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (PSEL && !PENABLE) begin
          w_capture = 1'b1;
          w_next    = S_ADDR;
        end
      end
      S_ADDR: begin
        HTRANS = 2'b10;
        HSIZE  = 3'b010;
        if (HREADY) begin
          w_next = S_DATA;
        end
`ifdef APB3TOAHB_TIMEOUT_EN
        else if (w_stall_expired) begin
          w_timeout = 1'b1;
          w_next    = S_RESP;
        end
`endif
      end
      S_DATA: begin
        if (HREADY) begin
          w_ahb_done = 1'b1;
          w_next     = S_RESP;
        end
`ifdef APB3TOAHB_TIMEOUT_EN
        else if (w_stall_expired) begin
          w_timeout = 1'b1;
          w_next    = S_RESP;
        end
`endif
      end
      S_RESP: begin
        PREADY  = 1'b1;
        PSLVERR = r_err;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // HRESP is only meaningful on the HREADY=1 cycle, which is exactly when
  // w_ahb_done fires; wait-cycle HRESP never reaches the error flag.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      if (w_capture) begin
        r_addr  <= {PADDR[31:2], 2'b00};
        r_write <= PWRITE;
        r_wdata <= PWDATA;
        r_err   <= 1'b0;
      end
      if (w_ahb_done) begin
        r_err <= HRESP;
        if (!r_write) begin
          r_rdata <= HRDATA;
        end
      end
`ifdef APB3TOAHB_TIMEOUT_EN
      if (w_timeout) begin
        r_err <= 1'b1;
      end
`endif
    end
  end

  assign HADDR  = r_addr;
  assign HWRITE = r_write;
  assign HWDATA = r_wdata;
  assign HBURST = 3'b000;
  assign PRDATA = r_rdata;

endmodule

// File: tb/tb_apb3_to_ahb_bridge.sv
module tb_apb3_to_ahb_bridge;

  logic        HCLK;
  logic        HRESET;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // results of the most recent apb_xfer
  int          o_lat;
  int          o_pready_cyc;
  int          o_nseq;
  logic [31:0] o_prdata;
  logic        o_slverr;
  logic [31:0] o_haddr;
  logic        o_hwrite;
  logic [2:0]  o_hsize;
  logic [1:0]  o_htrans_resp;
  logic        o_haddr_bad;
  logic        o_hwdata_bad;
  logic        o_slverr_bad;
  logic        o_pready_after;

  apb3_to_ahb_bridge #(.TIMEOUT_CYCLES(4)) dut (
    .HCLK    (HCLK),
    .HRESET  (HRESET),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR),
    .HADDR   (HADDR),
    .HTRANS  (HTRANS),
    .HWRITE  (HWRITE),
    .HSIZE   (HSIZE),
    .HBURST  (HBURST),
    .HWDATA  (HWDATA),
    .HRDATA  (HRDATA),
    .HREADY  (HREADY),
    .HRESP   (HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;

  // One APB transfer against a scripted AHB subordinate.
  // Cycle k counts cycles after the setup edge: aw address-phase stalls, then
  // address accepted, dw data-phase stalls, then the data-phase completion.
  task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                          input int aw, input int dw, input logic err, input logic noise,
                          input logic drop, input logic [31:0] rdata);
    bit done = 0;
    o_lat = -1; o_pready_cyc = 0; o_nseq = 0; o_prdata = 'x; o_slverr = 'x;
    o_haddr = 'x; o_hwrite = 'x; o_hsize = 'x; o_htrans_resp = 'x;
    o_haddr_bad = 0; o_hwdata_bad = 0; o_slverr_bad = 0;
    PSEL = 1; PENABLE = 0; PADDR = addr; PWRITE = wr; PWDATA = wdata;
    HREADY = 1; HRESP = 0; HRDATA = 32'hBAD0_BAD0;
    @(posedge HCLK);
    for (int k = 1; k <= 40 && !done; k++) begin
      #1;
      if (drop) begin
        PSEL = 0; PENABLE = 0; PADDR = 32'hFFFF_FFFC; PWRITE = ~wr; PWDATA = ~wdata;
      end else begin
        PENABLE = 1;
      end
      HRDATA = 32'hBAD0_BAD0; HRESP = 0;
      if (k <= aw) HREADY = 0;
      else if (k == aw + 1) HREADY = 1;
      else if (k <= aw + 1 + dw) begin
        HREADY = 0;
        HRESP  = noise || (err && k == aw + 1 + dw);
      end else if (k == aw + dw + 2) begin
        HREADY = 1; HRESP = err; HRDATA = rdata;
      end else HREADY = 1;
      @(negedge HCLK);
      if (HTRANS === 2'b10) begin
        o_nseq++;
        if (o_nseq == 1) begin
          o_haddr = HADDR; o_hwrite = HWRITE; o_hsize = HSIZE;
        end else if (HADDR !== o_haddr || HWRITE !== o_hwrite) o_haddr_bad = 1;
      end
      if (wr && k >= aw + 2 && k <= aw + dw + 2 && HWDATA !== wdata) o_hwdata_bad = 1;
      if (PREADY !== 1'b1 && PSLVERR !== 1'b0) o_slverr_bad = 1;
      if (PREADY === 1'b1) begin
        o_lat = k; o_pready_cyc = cyc; o_prdata = PRDATA; o_slverr = PSLVERR;
        o_htrans_resp = HTRANS; done = 1;
      end
      @(posedge HCLK);
    end
    #1;
    o_pready_after = PREADY;
    PSEL = 0; PENABLE = 0; HREADY = 1; HRESP = 0; HRDATA = 32'hBAD0_BAD0;
  endtask

  task automatic test_reset;
    HRESET = 1; PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 32'h1234_5678;
    PWDATA = 32'hFFFF_FFFF; HRDATA = 32'hFFFF_FFFF; HREADY = 1; HRESP = 1;
    #3;
    checks++; if ({HTRANS, PREADY, PSLVERR} !== 4'b0) begin errors++;
      $display("FAIL reset_ctrl: got htrans/pready/pslverr=%b expected 0000", {HTRANS, PREADY, PSLVERR}); end
    checks++; if (PRDATA !== 32'h0) begin errors++;
      $display("FAIL reset_prdata: got %h expected 00000000", PRDATA); end
    checks++; if ({HADDR, HWDATA, HWRITE, HSIZE, HBURST} !== '0) begin errors++;
      $display("FAIL reset_ahb: got haddr=%h hwdata=%h hwrite=%b hsize=%b hburst=%b expected all 0",
               HADDR, HWDATA, HWRITE, HSIZE, HBURST); end
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    checks++; if (HTRANS !== 2'b00) begin errors++;
      $display("FAIL reset_hold_htrans: got %b expected 00", HTRANS); end
    PSEL = 0; HRESP = 0; HRESET = 0;
  endtask

  task automatic test_zero_wait_write;
    apb_xfer(32'h4000_0013, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 32'h0);
    checks++; if (o_lat !== 3) begin errors++;
      $display("FAIL zw_write_latency: got %0d expected 3", o_lat); end
    checks++; if (o_nseq !== 1) begin errors++;
      $display("FAIL zw_write_nonseq_cycles: got %0d expected 1", o_nseq); end
    checks++; if (o_haddr !== 32'h4000_0010 || o_hwrite !== 1'b1 || o_hsize !== 3'b010) begin errors++;
      $display("FAIL zw_write_addr_phase: got haddr=%h hwrite=%b hsize=%b expected 40000010 1 010",
               o_haddr, o_hwrite, o_hsize); end
    checks++; if (o_hwdata_bad !== 1'b0) begin errors++;
      $display("FAIL zw_write_hwdata: got mismatch flag %b expected 0 (hwdata deadbeef)", o_hwdata_bad); end
    checks++; if (o_slverr !== 1'b0 || o_slverr_bad !== 1'b0) begin errors++;
      $display("FAIL zw_write_pslverr: got %b (idle flag %b) expected 0", o_slverr, o_slverr_bad); end
    checks++; if (o_pready_after !== 1'b0) begin errors++;
      $display("FAIL zw_write_pready_pulse: got %b after resp expected 0", o_pready_after); end
    checks++; if (o_prdata !== 32'h0) begin errors++;
      $display("FAIL zw_write_prdata: got %h expected 00000000", o_prdata); end
  endtask

  task automatic test_read_waits;
    apb_xfer(32'h0000_0100, 0, 32'h0, 0, 2, 0, 0, 0, 32'h1234_5678);
    checks++; if (o_lat !== 5) begin errors++;
      $display("FAIL read_dwait_latency: got %0d expected 5", o_lat); end
    checks++; if (o_prdata !== 32'h1234_5678 || o_slverr !== 1'b0) begin errors++;
      $display("FAIL read_dwait_data: got prdata=%h pslverr=%b expected 12345678 0", o_prdata, o_slverr); end
    checks++; if (o_hwrite !== 1'b0 || o_haddr !== 32'h0000_0100) begin errors++;
      $display("FAIL read_dwait_addr: got haddr=%h hwrite=%b expected 00000100 0", o_haddr, o_hwrite); end
    apb_xfer(32'h0000_0022, 0, 32'h0, 2, 0, 0, 0, 0, 32'hA5A5_0020);
    checks++; if (o_lat !== 5 || o_nseq !== 3) begin errors++;
      $display("FAIL read_await_timing: got latency=%0d nonseq=%0d expected 5 3", o_lat, o_nseq); end
    checks++; if (o_haddr_bad !== 1'b0 || o_haddr !== 32'h0000_0020) begin errors++;
      $display("FAIL read_await_stable: got haddr=%h unstable=%b expected 00000020 0", o_haddr, o_haddr_bad); end
    checks++; if (o_prdata !== 32'hA5A5_0020) begin errors++;
      $display("FAIL read_await_data: got %h expected a5a50020", o_prdata); end
  endtask

  task automatic test_write_keeps_prdata;
    apb_xfer(32'h8000_0104, 1, 32'h0BAD_F00D, 0, 2, 0, 0, 0, 32'h7777_7777);
    checks++; if (o_lat !== 5 || o_hwdata_bad !== 1'b0) begin errors++;
      $display("FAIL write_dwait: got latency=%0d hwdata_unstable=%b expected 5 0", o_lat, o_hwdata_bad); end
    checks++; if (o_prdata !== 32'hA5A5_0020) begin errors++;
      $display("FAIL write_keeps_prdata: got %h expected a5a50020", o_prdata); end
  endtask

  task automatic test_ahb_error;
    apb_xfer(32'h0000_0040, 1, 32'h0000_00E1, 0, 1, 1, 0, 0, 32'h0);
    checks++; if (o_lat !== 4 || o_slverr !== 1'b1) begin errors++;
      $display("FAIL err_write: got latency=%0d pslverr=%b expected 4 1", o_lat, o_slverr); end
    checks++; if (o_slverr_bad !== 1'b0) begin errors++;
      $display("FAIL err_write_pslverr_idle: got flag %b expected 0", o_slverr_bad); end
    apb_xfer(32'h0000_0030, 0, 32'h0, 0, 0, 0, 0, 0, 32'h3030_3030);
    checks++; if (o_lat !== 3 || o_slverr !== 1'b0 || o_prdata !== 32'h3030_3030) begin errors++;
      $display("FAIL err_followup_read: got latency=%0d pslverr=%b prdata=%h expected 3 0 30303030",
               o_lat, o_slverr, o_prdata); end
    apb_xfer(32'h0000_0050, 0, 32'h0, 0, 0, 1, 0, 0, 32'hE770_7000);
    checks++; if (o_slverr !== 1'b1 || o_prdata !== 32'hE770_7000) begin errors++;
      $display("FAIL err_read: got pslverr=%b prdata=%h expected 1 e7707000", o_slverr, o_prdata); end
    apb_xfer(32'h0000_0060, 0, 32'h0, 0, 2, 0, 1, 0, 32'h0000_0042);
    checks++; if (o_slverr !== 1'b0 || o_prdata !== 32'h0000_0042 || o_lat !== 5) begin errors++;
      $display("FAIL hresp_wait_ignored: got pslverr=%b prdata=%h latency=%0d expected 0 00000042 5",
               o_slverr, o_prdata, o_lat); end
  endtask

  task automatic test_psel_drop;
    apb_xfer(32'h0000_0044, 0, 32'h0, 0, 0, 0, 0, 1, 32'h4444_4444);
    checks++; if (o_lat !== 3 || o_prdata !== 32'h4444_4444 || o_haddr !== 32'h0000_0044) begin errors++;
      $display("FAIL psel_drop: got latency=%0d prdata=%h haddr=%h expected 3 44444444 00000044",
               o_lat, o_prdata, o_haddr); end
  endtask

  task automatic test_back_to_back;
    int          c0;
    logic [31:0] d0;
    apb_xfer(32'h0000_0010, 0, 32'h0, 0, 0, 0, 0, 0, 32'h1111_0010);
    c0 = o_pready_cyc; d0 = o_prdata;
    apb_xfer(32'h0000_0014, 0, 32'h0, 0, 0, 0, 0, 0, 32'h2222_0014);
    checks++; if (d0 !== 32'h1111_0010 || o_prdata !== 32'h2222_0014) begin errors++;
      $display("FAIL b2b_data: got %h %h expected 11110010 22220014", d0, o_prdata); end
    checks++; if (o_pready_cyc - c0 !== 4 || o_lat !== 3) begin errors++;
      $display("FAIL b2b_spacing: got %0d cycles (latency %0d) expected 4 (3)", o_pready_cyc - c0, o_lat); end
  endtask

  task automatic test_reset_mid;
    PSEL = 1; PENABLE = 0; PADDR = 32'h0000_0F04; PWRITE = 1; PWDATA = 32'h5555_AAAA; HREADY = 1;
    @(posedge HCLK); #1; PENABLE = 1;
    @(posedge HCLK); #1; HREADY = 0;
    @(negedge HCLK);
    checks++; if (HWDATA !== 32'h5555_AAAA || HTRANS !== 2'b00) begin errors++;
      $display("FAIL mid_pre_reset: got hwdata=%h htrans=%b expected 5555aaaa 00", HWDATA, HTRANS); end
    HRESET = 1; #1;
    checks++; if ({HTRANS, PREADY, PSLVERR, HWRITE} !== 5'b0 || PRDATA !== 32'h0
                  || HADDR !== 32'h0 || HWDATA !== 32'h0) begin errors++;
      $display("FAIL mid_reset_outputs: got htrans=%b pready=%b pslverr=%b prdata=%h haddr=%h hwdata=%h expected all 0",
               HTRANS, PREADY, PSLVERR, PRDATA, HADDR, HWDATA); end
    @(posedge HCLK);
    PSEL = 0; PENABLE = 0; HREADY = 1;
    @(negedge HCLK);
    HRESET = 0;
    apb_xfer(32'h0000_0008, 0, 32'h0, 0, 0, 0, 0, 0, 32'h600D_600D);
    checks++; if (o_lat !== 3 || o_prdata !== 32'h600D_600D) begin errors++;
      $display("FAIL post_reset_xfer: got latency=%0d prdata=%h expected 3 600d600d", o_lat, o_prdata); end
  endtask

`ifdef APB3TOAHB_TIMEOUT_EN
  task automatic test_timeout;
    apb_xfer(32'h0000_0070, 0, 32'h0, 20, 0, 0, 0, 0, 32'h9999_9999);
    checks++; if (o_lat !== 5 || o_slverr !== 1'b1) begin errors++;
      $display("FAIL timeout_resp: got latency=%0d pslverr=%b expected 5 1", o_lat, o_slverr); end
    checks++; if (o_htrans_resp !== 2'b00 || o_prdata !== 32'h600D_600D) begin errors++;
      $display("FAIL timeout_state: got htrans=%b prdata=%h expected 00 600d600d", o_htrans_resp, o_prdata); end
    apb_xfer(32'h0000_0074, 0, 32'h0, 1, 0, 0, 0, 0, 32'h7474_7474);
    checks++; if (o_lat !== 4 || o_slverr !== 1'b0 || o_prdata !== 32'h7474_7474) begin errors++;
      $display("FAIL timeout_recovery: got latency=%0d pslverr=%b prdata=%h expected 4 0 74747474",
               o_lat, o_slverr, o_prdata); end
  endtask
`endif

  initial begin
    test_reset;
    test_zero_wait_write;
    test_read_waits;
    test_write_keeps_prdata;
    test_ahb_error;
    test_psel_drop;
    test_back_to_back;
    test_reset_mid;
`ifdef APB3TOAHB_TIMEOUT_EN
    test_timeout;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
